// File: rtl/apb_timer_irq_pkg.sv
// Shared register map, control bit positions and APB handshake states for apb_timer_irq.
package apb_timer_irq_pkg;

    localparam logic [4:0] ADDR_CTRL  = 5'h00;
    localparam logic [4:0] ADDR_STAT  = 5'h04;
    localparam logic [4:0] ADDR_COUNT = 5'h08;
    localparam logic [4:0] ADDR_CMP   = 5'h0C;
    localparam logic [4:0] ADDR_PRESC = 5'h10;
    localparam logic [4:0] ADDR_EPEND = 5'h14;
    localparam logic [4:0] ADDR_EEN   = 5'h18;

    localparam int CTRL_TEN = 0;
    localparam int CTRL_TIE = 1;
    localparam int CTRL_ARL = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } apb_state_t;

    // Anything past the last register or not word aligned is rejected.
    function automatic logic addr_error(input logic [4:0] addr);
        return (addr > ADDR_EEN) || (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/apb_irq_edge_sync.sv
// Per-line two-flop synchroniser followed by a rising-edge detector on the synced value.
module apb_irq_edge_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         srst,
    input  logic [W-1:0] async_in,
    output logic [W-1:0] rise
);

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_line
            logic meta_reg;
            logic sync_reg;
            logic prev_reg;

            always_ff @(posedge clk) begin
                if (srst) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                    prev_reg <= 1'b0;
                end else begin
                    meta_reg <= async_in[gi];
                    sync_reg <= meta_reg;
                    prev_reg <= sync_reg;
                end
            end

            assign rise[gi] = sync_reg & ~prev_reg;
        end
    endgenerate

endmodule

// File: rtl/apb_timer_irq.sv
// APB timer with compare plus edge-triggered external lines, merged into one level interrupt.
module apb_timer_irq
    import apb_timer_irq_pkg::*;
#(
    parameter int USE_PENABLE = 1,
    parameter int N_EXT       = 4,
    parameter int PRESC_W     = 8
) (
    input  logic             APB_PCLK,
    input  logic             APB_PRESET,
    input  logic             APB_psel,
    input  logic             APB_penable,
    input  logic             APB_pwrite,
    input  logic [4:0]       APB_paddr,
    input  logic [31:0]      APB_pwdata,
    output logic [31:0]      APB_prdata,
    output logic             APB_pready,
    output logic             APB_perr,
    input  logic [N_EXT-1:0] ext_irq,
    output logic             interrupt
);

    apb_state_t state_reg, state_next;
    logic               access, commit, addr_err, wr_ok;
    logic               wr_ctrl, wr_stat, wr_count, wr_cmp, wr_presc, wr_epend, wr_een;
    logic [31:0]        rdata;
    logic [2:0]         ctrl_reg;
    logic               tpend_reg;
    logic [31:0]        count_reg, cmp_reg;
    logic [PRESC_W-1:0] presc_reg, pcnt_reg;
    logic [N_EXT-1:0]   epend_reg, een_reg, ext_rise, epend_clr;
    logic [31:0]        prdata_reg;
    logic               perr_reg, irq_reg;
    logic               tick, match;

    assign access = APB_psel && (APB_penable || (USE_PENABLE == 0));

    always_comb begin
        state_next = state_reg;
        commit     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (access) begin
                    state_next = ST_ACK;
                    commit     = 1'b1;
                end
            end
            ST_ACK:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign addr_err = addr_error(APB_paddr);
    assign wr_ok    = commit && APB_pwrite && !addr_err;
    assign wr_ctrl  = wr_ok && (APB_paddr == ADDR_CTRL);
    assign wr_stat  = wr_ok && (APB_paddr == ADDR_STAT);
    assign wr_count = wr_ok && (APB_paddr == ADDR_COUNT);
    assign wr_cmp   = wr_ok && (APB_paddr == ADDR_CMP);
    assign wr_presc = wr_ok && (APB_paddr == ADDR_PRESC);
    assign wr_epend = wr_ok && (APB_paddr == ADDR_EPEND);
    assign wr_een   = wr_ok && (APB_paddr == ADDR_EEN);

    always_comb begin
        rdata = '0;
        case (APB_paddr)
            ADDR_CTRL:  rdata[2:0]         = ctrl_reg;
            ADDR_STAT:  rdata[0]           = tpend_reg;
            ADDR_COUNT: rdata              = count_reg;
            ADDR_CMP:   rdata              = cmp_reg;
            ADDR_PRESC: rdata[PRESC_W-1:0] = presc_reg;
            ADDR_EPEND: rdata[N_EXT-1:0]   = epend_reg;
            ADDR_EEN:   rdata[N_EXT-1:0]   = een_reg;
            default:    rdata              = '0;
        endcase
    end

    assign tick      = ctrl_reg[CTRL_TEN] && (pcnt_reg == presc_reg);
    assign match     = tick && (count_reg == cmp_reg);
    assign epend_clr = wr_epend ? APB_pwdata[N_EXT-1:0] : '0;

    apb_irq_edge_sync #(.W(N_EXT)) u_edge_sync (
        .clk      (APB_PCLK),
        .srst     (APB_PRESET),
        .async_in (ext_irq),
        .rise     (ext_rise)
    );

    always_ff @(posedge APB_PCLK) begin
        if (APB_PRESET) begin
            state_reg  <= ST_IDLE;
            prdata_reg <= '0;
            perr_reg   <= 1'b0;
            ctrl_reg   <= '0;
            tpend_reg  <= 1'b0;
            count_reg  <= '0;
            cmp_reg    <= '0;
            presc_reg  <= '0;
            pcnt_reg   <= '0;
            epend_reg  <= '0;
            een_reg    <= '0;
            irq_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (commit) begin
                prdata_reg <= addr_err ? '0 : rdata;
                perr_reg   <= addr_err;
            end
            if (wr_ctrl)  ctrl_reg  <= APB_pwdata[2:0];
            if (wr_cmp)   cmp_reg   <= APB_pwdata;
            if (wr_presc) presc_reg <= APB_pwdata[PRESC_W-1:0];
            if (wr_een)   een_reg   <= APB_pwdata[N_EXT-1:0];

            // Rewriting PRESC restarts the divide so the new period takes effect cleanly.
            if (wr_presc || !ctrl_reg[CTRL_TEN] || tick)
                pcnt_reg <= '0;
            else
                pcnt_reg <= pcnt_reg + 1'b1;

            if (wr_count)
                count_reg <= APB_pwdata;
            else if (tick)
                count_reg <= (match && ctrl_reg[CTRL_ARL]) ? 32'd0 : count_reg + 32'd1;

            // A hardware set in the same cycle as a W1C wins.
            tpend_reg <= match | (tpend_reg & ~(wr_stat & APB_pwdata[0]));
            epend_reg <= ext_rise | (epend_reg & ~epend_clr);
            irq_reg   <= (tpend_reg & ctrl_reg[CTRL_TIE]) | (|(epend_reg & een_reg));
        end
    end

    assign APB_prdata = prdata_reg;
    assign APB_pready = (state_reg == ST_ACK);
    assign APB_perr   = perr_reg;
    assign interrupt  = irq_reg;

endmodule
